comparator_iterative: RTL and testbench

//   Multi-cycle comparator for wide operands (64-bit and up).

---
 rtl/comparator_iterative.sv | 145 ++++++++++++++
 tb/tb_comparator_iterative.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_iterative.sv
// Iterative wide comparator: scans operands MSB-first, CHUNK bits per cycle,
// and stops at the first differing chunk. Produces signed and unsigned
// relational flags behind a valid/ready handshake, so a wide compare never
// sits in a single-cycle timing path.

package signals;
  // Full comparison flag set, eq in the MSB.
  typedef struct packed {
    logic eq;
    logic neq;
    logic gt;
    logic lt;
    logic gtu;
    logic ltu;
  } compare_t;
endpackage

module comparator_iterative #(
  parameter int N     = 64,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output signals::compare_t result
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Reject configurations where the chunks would not tile the operand exactly.
  if (CHUNK < 1 || CHUNK > N) begin : g_bad_chunk_range
    $error("comparator_iterative: CHUNK must satisfy 1 <= CHUNK <= N");
  end
  if (N % CHUNK != 0) begin : g_bad_chunk_tiling
    $error("comparator_iterative: N must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [N-1:0]        a_q;
  logic [N-1:0]        b_q;
  logic                in_ready_q;
  logic                out_valid_q;
  signals::compare_t   result_q;

  logic [CHUNK-1:0]    chunk_a;
  logic [CHUNK-1:0]    chunk_b;
  logic                chunk_ne;
  logic                chunk_gt;
  logic                sa;
  logic                sb;
  signals::compare_t   result_d;

  // Select the current chunk and form the flag set that would be committed if
  // the scan ended on this chunk.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    chunk_a  = a_q[N-1-int'(idx_q)*CHUNK -: CHUNK];
    chunk_b  = b_q[N-1-int'(idx_q)*CHUNK -: CHUNK];
    chunk_ne = (chunk_a != chunk_b);
    chunk_gt = (chunk_a > chunk_b);
    sa       = a_q[N-1];
    sb       = b_q[N-1];
    result_d = '0;
    // Unsigned order is decided by the first differing chunk; if we finish on
    // an equal chunk it can only be the last one, so the operands are equal.
    result_d.eq  = ~chunk_ne;
    result_d.neq = chunk_ne;
    result_d.gtu = chunk_ne & chunk_gt;
    result_d.ltu = chunk_ne & ~chunk_gt;
    // Differing sign bits decide the signed order outright; otherwise it
    // matches the unsigned order.
    result_d.gt  = (~sa & sb) | (~(sa ^ sb) & result_d.gtu);
    result_d.lt  = (sa & ~sb) | (~(sa ^ sb) & result_d.ltu);
  end

  // Handshake/scan FSM with registered outputs and latched operand copies.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      // NOTE: the operand copies are reset as well, so result_d never sees
      // X operands even though nothing commits it before the first accept.
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (chunk_ne || (idx_q == LAST_IDX)) begin
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_comparator_iterative.sv
// Bench for comparator_iterative: a 64-bit/8-bit-chunk instance driven with
// directed and biased-random operands, plus a 32-bit single-chunk instance.
// Expected flags come from plain signed/unsigned arithmetic; expected latency
// comes from the position of the highest differing bit.

module tb_comparator_iterative;
  import signals::*;

  localparam int N      = 64;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = N / CHUNK;
  localparam int N1     = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  a, b;
  compare_t      result;

  logic          in_valid1, in_ready1, out_valid1, out_ready1;
  logic [N1-1:0] a1, b1;
  compare_t      result1;

  comparator_iterative #(.N(N), .CHUNK(CHUNK)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  comparator_iterative #(.N(N1), .CHUNK(N1)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .result    (result1)
  );

  int       n_total = 0;
  int       n_pass  = 0;
  compare_t exp_res  = '0;
  compare_t exp_res1 = '0;
  int       exp_lat  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Golden flags: operands are zero-extended n-bit values; shifting both to
  // the top of 128 bits makes $signed see the n-bit sign bit.
  function automatic compare_t model(input logic [127:0] av, input logic [127:0] bv, input int n);
    compare_t     r;
    logic [127:0] as_v;
    logic [127:0] bs_v;
    as_v  = av << (128 - n);
    bs_v  = bv << (128 - n);
    r.eq  = (av == bv);
    r.neq = (av != bv);
    r.gtu = (as_v > bs_v);
    r.ltu = (as_v < bs_v);
    r.gt  = ($signed(as_v) > $signed(bs_v));
    r.lt  = ($signed(as_v) < $signed(bs_v));
    return r;
  endfunction

  // Golden latency: d = chunk holding the highest differing bit, latency d+1;
  // equal operands take one edge per chunk.
  function automatic int model_lat(input logic [127:0] av, input logic [127:0] bv,
                                   input int n, input int chunk);
    logic [127:0] x;
    x = av ^ bv;
    for (int p = n - 1; p >= 0; p--) begin
      if (x[p]) return (n - 1 - p) / chunk + 1;
    end
    return n / chunk;
  endfunction

  // Whenever a result is presented it must equal the model and block new input.
  always @(negedge clk) begin
    if (out_valid) begin
      check("mon_result", result, exp_res);
      check("mon_in_ready_low", in_ready, 0);
    end
    if (out_valid1) check("mon1_result", result1, exp_res1);
  end

  // Present one operand pair, wait for acceptance, then scramble the ports.
  task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    exp_res  = model(128'(av), 128'(bv), N);
    exp_lat  = model_lat(128'(av), 128'(bv), N, CHUNK);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~av;
    b        = {$urandom, $urandom};
  endtask

  // Measure latency, optionally stall the consumer (and poke new operands
  // during the stall), then complete the output handshake.
  task automatic finish_op(input int hold, input bit poke,
                           input logic [N-1:0] pa, input logic [N-1:0] pb);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
    check("latency", lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 0) begin
        a        = pa;
        b        = pb;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    check("drain_result_held", result, exp_res);
  endtask

  task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, input int hold);
    start_op(av, bv);
    finish_op(hold, 1'b0, '0, '0);
  endtask

  // Single-chunk instance: every operation must complete in one edge.
  task automatic op1(input logic [N1-1:0] av, input logic [N1-1:0] bv);
    int lat;
    lat = 0;
    @(negedge clk);
    check("dut1_in_ready", in_ready1, 1);
    exp_res1  = model(128'(av), 128'(bv), N1);
    a1        = av;
    b1        = bv;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    a1        = ~av;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid1 && lat < 20);
    check("dut1_latency", lat, 1);
    check("dut1_result", result1, exp_res1);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    check("dut1_drain", {out_valid1, in_ready1}, 2'b01);
  endtask

  initial begin
    logic [N-1:0]  ra, rb;
    logic [N1-1:0] qa, qb;
    int            k;

    reset_n    = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;
    a1         = '0;
    b1         = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset1_in_ready", in_ready1, 1);
    reset_n = 1'b1;

    // Hand-computed values pin the model itself.
    check("model_eq_lit", model(128'(64'h0123_4567_89AB_CDEF), 128'(64'h0123_4567_89AB_CDEF), N), 6'b100000);
    check("model_sign_lit", model(128'(64'h8000_0000_0000_0000), 128'(64'h1), N), 6'b010110);
    check("model_d6_lit", model(128'(64'h100), 128'(64'hFF), N), 6'b011010);
    check("model_lat_eq_lit", model_lat(128'(64'h5), 128'(64'h5), N, CHUNK), 8);
    check("model_lat_d6_lit", model_lat(128'(64'h100), 128'(64'hFF), N, CHUNK), 7);

    // Equal operands: full scan.
    do_op(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);
    check("t1_result_lit", result, 6'b100000);
    check("t1_latency_lit", exp_lat, NCHUNK);

    // Top chunk differs; signed and unsigned orders disagree.
    do_op(64'h8000_0000_0000_0000, 64'h1, 0);
    check("t2_result_lit", result, 6'b010110);
    check("t2_latency_lit", exp_lat, 1);

    // First difference in chunk 6.
    do_op(64'h100, 64'hFF, 0);
    check("t3_result_lit", result, 6'b011010);

    // Consumer stalls for 5 cycles while new operands are offered.
    start_op(64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0001);
    finish_op(5, 1'b1, 64'h7, 64'h9);
    check("t4_result_lit", result, 6'b010101);
    do_op(64'h7, 64'h9, 0);
    check("t4_after_drain_lit", result, 6'b010101);

    // Asynchronous reset while scanning chunk index 3.
    start_op(64'hDEAD_BEEF_DEAD_BEEF, 64'hDEAD_BEEF_DEAD_BEEF);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_out_valid_async", out_valid, 0);
    check("t5_in_ready_async", in_ready, 1);
    check("t5_result_cleared", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_no_stale_valid", out_valid, 0);
    end
    do_op(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check("t5_after_reset_lit", result, 6'b010101);

    // Biased random: equal pairs and single-bit flips reach every chunk index.
    for (int n = 0; n < 300; n++) begin
      ra = {$urandom, $urandom};
      k  = int'($urandom_range(0, 3));
      if (k == 0) rb = {$urandom, $urandom};
      else if (k == 1) rb = ra;
      else rb = ra ^ (64'(1) << $urandom_range(0, N - 1));
      do_op(ra, rb, int'($urandom_range(0, 2)));
    end

    // Single-chunk configuration.
    op1(32'h8000_0000, 32'h7FFF_FFFF);
    check("dut1_sign_lit", result1, 6'b010110);
    op1(32'h1234_5678, 32'h1234_5678);
    check("dut1_eq_lit", result1, 6'b100000);
    for (int n = 0; n < 100; n++) begin
      qa = $urandom;
      qb = ($urandom_range(0, 3) == 0) ? qa : 32'($urandom);
      op1(qa, qb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
